// File: rtl/tdm_mux_pkg.sv
// Shared constants and state encoding for the time-division channel multiplexer.
package tdm_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_scan_ctr.sv
// Round-robin channel pointer with a per-channel dwell counter for SCAN mode.
module tdm_scan_ctr #(
  parameter int N_CH  = 8,
  parameter int DWELL = 1,
  parameter int SELW  = $clog2(N_CH),
  parameter int CW    = $clog2(DWELL + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            adv,
  output logic [SELW-1:0] ptr,
  output logic            last
);

  localparam logic [SELW-1:0] LAST_PTR = SELW'(N_CH - 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);

  logic [CW-1:0] dwell_cnt;
  logic          dwell_done;

  assign dwell_done = (dwell_cnt == LAST_CNT);
  assign last       = dwell_done && (ptr == LAST_PTR);

  // Pointer wraps explicitly at N_CH-1 so non-power-of-two channel counts never
  // reach an unused index.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr       <= '0;
      dwell_cnt <= '0;
    end else if (adv) begin
      if (dwell_done) begin
        dwell_cnt <= '0;
        ptr       <= (ptr == LAST_PTR) ? '0 : ptr + SELW'(1);
      end else begin
        dwell_cnt <= dwell_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/tdm_mux.sv
// N-channel registered multiplexer with manual select and round-robin scan modes.
//   state     | meaning
//   ST_MANUAL | enabled cycles sample the channel named by sel_in
//   ST_SCAN   | enabled cycles sample the channel under the scan pointer
module tdm_mux
  import tdm_mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int DW    = 1,
  parameter int DWELL = 1,
  parameter int SELW  = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [SELW-1:0]   sel_in,
  input  logic [N_CH*DW-1:0] din,
  output logic [DW-1:0]     dout,
  output logic [SELW-1:0]   sel_out,
  output logic              valid,
  output logic              wrap
);

  state_t          state;
  logic [SELW-1:0] ptr;
  logic            last;
  logic            scan_clr;
  logic            scan_adv;
  logic [DW:0]     man_pick;
  logic [DW:0]     scan_pick;

  // Returns {hit, data}; hit is low for indices past the last channel.
  function automatic logic [DW:0] pick(input logic [SELW-1:0] s,
                                       input logic [N_CH*DW-1:0] d);
    logic [DW:0] r;
    r = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (s == SELW'(k)) r = {1'b1, d[k*DW +: DW]};
    end
    return r;
  endfunction

  assign man_pick  = pick(sel_in, din);
  assign scan_pick = pick(ptr, din);

  // Entering SCAN always restarts the sweep, whatever en is doing.
  assign scan_clr = (state == ST_MANUAL) && (mode == MODE_SCAN);
  assign scan_adv = (state == ST_SCAN) && en;

  tdm_scan_ctr #(
    .N_CH  (N_CH),
    .DWELL (DWELL)
  ) u_scan_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (scan_clr),
    .adv  (scan_adv),
    .ptr  (ptr),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_MANUAL;
      dout    <= '0;
      sel_out <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      case (state)
        ST_MANUAL: if (mode == MODE_SCAN)   state <= ST_SCAN;
        ST_SCAN:   if (mode == MODE_MANUAL) state <= ST_MANUAL;
        default:   state <= ST_MANUAL;
      endcase

      if (!en) begin
        valid <= 1'b0;
        wrap  <= 1'b0;
      end else if (state == ST_SCAN) begin
        dout    <= scan_pick[DW-1:0];
        sel_out <= ptr;
        valid   <= 1'b1;
        wrap    <= last;
      end else begin
        dout    <= man_pick[DW] ? man_pick[DW-1:0] : '0;
        sel_out <= sel_in;
        valid   <= man_pick[DW];
        wrap    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux.sv
// Directed bench: three tdm_mux instances (8ch/dwell1, 8ch/dwell3, 6ch/dwell1) on shared controls.
module tb_tdm_mux;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic [2:0] sel_in;
  logic [7:0] din8;
  logic [5:0] din6;

  logic       d1_dout, d3_dout, n6_dout;
  logic [2:0] d1_sel, d3_sel, n6_sel;
  logic       d1_valid, d3_valid, n6_valid;
  logic       d1_wrap, d3_wrap, n6_wrap;

  int n_vec;
  int n_miss;

  tdm_mux #(.N_CH(8), .DW(1), .DWELL(1)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .din(din8),
    .dout(d1_dout), .sel_out(d1_sel), .valid(d1_valid), .wrap(d1_wrap));

  tdm_mux #(.N_CH(8), .DW(1), .DWELL(3)) u_d3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .din(din8),
    .dout(d3_dout), .sel_out(d3_sel), .valid(d3_valid), .wrap(d3_wrap));

  tdm_mux #(.N_CH(6), .DW(1), .DWELL(1)) u_n6 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in), .din(din6),
    .dout(n6_dout), .sel_out(n6_sel), .valid(n6_valid), .wrap(n6_wrap));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are read 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leave SCAN (en low), then re-enter: sweep restarts at channel 0.
  task automatic restart_scan();
    en = 1'b0; mode = 1'b0; step();
    mode = 1'b1; step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel_in = 3'd0;
    step(); step();
    if ({d1_dout, d1_sel, d1_valid, d1_wrap} !== 6'b0) begin
      $display("FAIL reset_d1 got=%b want=000000", {d1_dout, d1_sel, d1_valid, d1_wrap}); n_miss++;
    end
    n_vec++;
    if ({d3_dout, d3_sel, d3_valid, d3_wrap} !== 6'b0) begin
      $display("FAIL reset_d3 got=%b want=000000", {d3_dout, d3_sel, d3_valid, d3_wrap}); n_miss++;
    end
    n_vec++;
    if ({n6_dout, n6_sel, n6_valid, n6_wrap} !== 6'b0) begin
      $display("FAIL reset_n6 got=%b want=000000", {n6_dout, n6_sel, n6_valid, n6_wrap}); n_miss++;
    end
    n_vec++;
    rst = 1'b0;
  endtask

  task automatic test_manual();
    logic [7:0] exp_d = 8'b10101010;
    mode = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel_in = 3'(i);
      step();
      if (d1_dout !== exp_d[i] || d1_sel !== 3'(i) || d1_valid !== 1'b1 || d1_wrap !== 1'b0) begin
        $display("FAIL manual ch%0d got dout=%b sel=%0d v=%b w=%b want dout=%b sel=%0d v=1 w=0",
                 i, d1_dout, d1_sel, d1_valid, d1_wrap, exp_d[i], i);
        n_miss++;
      end
      n_vec++;
    end
  endtask

  task automatic test_scan_dwell1();
    int wraps = 0;
    restart_scan();
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (d1_sel !== 3'(i % 8) || d1_dout !== 1'((i % 8) & 1) || d1_valid !== 1'b1 ||
          d1_wrap !== ((i % 8) == 7)) begin
        $display("FAIL scan_d1 i=%0d got sel=%0d dout=%b v=%b w=%b want sel=%0d dout=%0d v=1 w=%0d",
                 i, d1_sel, d1_dout, d1_valid, d1_wrap, i % 8, (i % 8) & 1, (i % 8) == 7);
        n_miss++;
      end
      n_vec++;
      if (d1_wrap === 1'b1) wraps++;
    end
    if (wraps != 2) begin
      $display("FAIL scan_d1_wrap_count got=%0d want=2", wraps); n_miss++;
    end
    n_vec++;
  endtask

  task automatic test_scan_dwell3();
    int ch;
    restart_scan();
    en = 1'b1;
    for (int i = 0; i < 48; i++) begin
      step();
      ch = (i / 3) % 8;
      if (d3_sel !== 3'(ch) || d3_dout !== 1'(ch & 1) || d3_valid !== 1'b1 ||
          d3_wrap !== (ch == 7 && (i % 3) == 2)) begin
        $display("FAIL scan_d3 i=%0d got sel=%0d dout=%b v=%b w=%b want sel=%0d dout=%0d v=1 w=%0d",
                 i, d3_sel, d3_dout, d3_valid, d3_wrap, ch, ch & 1, ch == 7 && (i % 3) == 2);
        n_miss++;
      end
      n_vec++;
    end
  endtask

  task automatic test_en_gap();
    restart_scan();
    en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (d1_dout !== 1'b1 || d1_sel !== 3'd3 || d1_valid !== 1'b0 || d1_wrap !== 1'b0) begin
        $display("FAIL en_gap_hold i=%0d got dout=%b sel=%0d v=%b w=%b want dout=1 sel=3 v=0 w=0",
                 i, d1_dout, d1_sel, d1_valid, d1_wrap);
        n_miss++;
      end
      n_vec++;
    end
    en = 1'b1;
    for (int i = 4; i < 8; i++) begin
      step();
      if (d1_sel !== 3'(i) || d1_valid !== 1'b1 || d1_wrap !== (i == 7)) begin
        $display("FAIL en_gap_resume got sel=%0d v=%b w=%b want sel=%0d v=1 w=%0d",
                 d1_sel, d1_valid, d1_wrap, i, i == 7);
        n_miss++;
      end
      n_vec++;
    end
  endtask

  task automatic test_reset_mid();
    restart_scan();
    en = 1'b1;
    for (int i = 0; i < 6; i++) step();
    if (d1_sel !== 3'd5) begin
      $display("FAIL reset_mid_pre got sel=%0d want sel=5", d1_sel); n_miss++;
    end
    n_vec++;
    rst = 1'b1;
    step();
    if ({d1_dout, d1_sel, d1_valid, d1_wrap} !== 6'b0) begin
      $display("FAIL reset_mid_clear got=%b want=000000", {d1_dout, d1_sel, d1_valid, d1_wrap});
      n_miss++;
    end
    n_vec++;
    rst = 1'b0; en = 1'b0;
    step();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (d1_sel !== 3'(i) || d1_dout !== 1'(i & 1) || d1_valid !== 1'b1) begin
        $display("FAIL reset_mid_restart got sel=%0d dout=%b v=%b want sel=%0d dout=%0d v=1",
                 d1_sel, d1_dout, d1_valid, i, i & 1);
        n_miss++;
      end
      n_vec++;
    end
  endtask

  task automatic test_mode_toggle();
    en = 1'b0; mode = 1'b0; step();
    en = 1'b1; sel_in = 3'd6; step();
    if (d1_sel !== 3'd6 || d1_dout !== 1'b0 || d1_valid !== 1'b1) begin
      $display("FAIL mode_manual got sel=%0d dout=%b v=%b want sel=6 dout=0 v=1",
               d1_sel, d1_dout, d1_valid);
      n_miss++;
    end
    n_vec++;
    en = 1'b0; mode = 1'b1; step();
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      if (d1_sel !== 3'(i) || d1_dout !== 1'(i & 1) || d1_valid !== 1'b1) begin
        $display("FAIL mode_rescan got sel=%0d dout=%b v=%b want sel=%0d dout=%0d v=1",
                 d1_sel, d1_dout, d1_valid, i, i & 1);
        n_miss++;
      end
      n_vec++;
    end
  endtask

  task automatic test_six_channels();
    logic [5:0] exp6 = 6'b110011;
    en = 1'b0; mode = 1'b0; step();
    en = 1'b1;
    sel_in = 3'd7; step();
    if (n6_valid !== 1'b0 || n6_dout !== 1'b0 || n6_sel !== 3'd7) begin
      $display("FAIL n6_sel7 got v=%b dout=%b sel=%0d want v=0 dout=0 sel=7", n6_valid, n6_dout, n6_sel);
      n_miss++;
    end
    n_vec++;
    sel_in = 3'd6; step();
    if (n6_valid !== 1'b0 || n6_dout !== 1'b0) begin
      $display("FAIL n6_sel6 got v=%b dout=%b want v=0 dout=0", n6_valid, n6_dout); n_miss++;
    end
    n_vec++;
    sel_in = 3'd4; step();
    if (n6_valid !== 1'b1 || n6_dout !== 1'b1 || n6_sel !== 3'd4) begin
      $display("FAIL n6_sel4 got v=%b dout=%b sel=%0d want v=1 dout=1 sel=4", n6_valid, n6_dout, n6_sel);
      n_miss++;
    end
    n_vec++;
    en = 1'b0; mode = 1'b1; step();
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (n6_sel !== 3'(i % 6) || n6_dout !== exp6[i % 6] || n6_valid !== 1'b1 ||
          n6_wrap !== ((i % 6) == 5)) begin
        $display("FAIL n6_scan i=%0d got sel=%0d dout=%b v=%b w=%b want sel=%0d dout=%b v=1 w=%0d",
                 i, n6_sel, n6_dout, n6_valid, n6_wrap, i % 6, exp6[i % 6], (i % 6) == 5);
        n_miss++;
      end
      n_vec++;
    end
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel_in = 3'd0;
    din8 = 8'b10101010;
    din6 = 6'b110011;
    test_reset();
    test_manual();
    test_scan_dwell1();
    test_scan_dwell3();
    test_en_gap();
    test_reset_mid();
    test_mode_toggle();
    test_six_channels();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
